// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, default width and counter sizing for piso_word_reader.
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
    localparam int PISO_DEFAULT_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/piso_stage.sv
// piso_stage: one bit of the shift register with parallel load and shift-enable mux.
module piso_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic shift_i,
    input  logic d_i,
    input  logic s_i,
    output logic q_o
);
    logic q_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q_q <= 1'b0;
        else if (load_i)  q_q <= d_i;
        else if (shift_i) q_q <= s_i;
    end
    assign q_o = q_q;
endmodule

// File: rtl/piso_word_reader.sv
// piso_word_reader: parallel-in serial-out reader with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity beat after the data bits.
module piso_word_reader
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             sout_o,
    output logic             sout_valid_o,
    input  logic             sout_ready_i,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = cnt_width(WIDTH);
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load, shift, data_bit;
    logic [WIDTH-1:0] sr_q, sr_in;
    assign sr_in = LSB_FIRST ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        piso_stage u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load),
            .shift_i(shift),
            .d_i    (load_data_i[i]),
            .s_i    (sr_in[i]),
            .q_o    (sr_q[i])
        );
    end
    assign data_bit = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
`ifdef PISO_PARITY_EN
    localparam state_e LAST_NEXT = PAR;
    logic par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    par_q <= 1'b0;
        else if (load) par_q <= ^load_data_i;
    end
    assign sout_o = (state_q == PAR) ? par_q : data_bit;
`else
    localparam state_e LAST_NEXT = IDLE;
    assign sout_o = data_bit;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                load = load_valid_i;
                if (load_valid_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sout_ready_i) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = LAST_NEXT;
                        done_d  = (LAST_NEXT == IDLE);
                    end
                end
            end
            default: begin
                if (sout_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end
    assign load_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign sout_valid_o = (state_q != IDLE);
    assign done_o       = done_q;
endmodule
